// File: rtl/mem_stage.sv
// MEM stage of the pipelined LEGv8 core: drives the multi-cycle data memory,
// owns NZCV, resolves branches and registers results toward MEM/WB and IF.
module mem_stage #(
   parameter int WORDSIZE    = 64,
   parameter int REGADDRSIZE = 5,
   parameter int FLAGSIZE    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_in,
   input  logic [6:0]             control_in,
   input  logic [WORDSIZE-1:0]    branchpc_in,
   input  logic [WORDSIZE-1:0]    alures_in,
   input  logic [WORDSIZE-1:0]    movres_in,
   input  logic [WORDSIZE-1:0]    readreg2_in,
   input  logic [FLAGSIZE-1:0]    flags_in,
   input  logic [REGADDRSIZE-1:0] rd_in,
   output logic                   stall,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [WORDSIZE-1:0]    mem_addr,
   output logic [WORDSIZE-1:0]    mem_wdata,
   input  logic                   mem_ack,
   input  logic [WORDSIZE-1:0]    mem_rdata,
   output logic                   wb_valid,
   output logic                   wb_regwrite,
   output logic [REGADDRSIZE-1:0] wb_rd,
   output logic [WORDSIZE-1:0]    wb_data,
   output logic                   pc_take,
   output logic [WORDSIZE-1:0]    pc_target,
   output logic [FLAGSIZE-1:0]    flags,
   output logic [1:0]             state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic                     mem_req_q, mem_req_d;
   logic                     mem_we_q, mem_we_d;
   logic [WORDSIZE-1:0]      mem_addr_q, mem_addr_d;
   logic [WORDSIZE-1:0]      mem_wdata_q, mem_wdata_d;
   logic [WORDSIZE-1:0]      rdata_q, rdata_d;
   logic                     wb_valid_q, wb_valid_d;
   logic                     wb_regwrite_q, wb_regwrite_d;
   logic [REGADDRSIZE-1:0]   wb_rd_q, wb_rd_d;
   logic [WORDSIZE-1:0]      wb_data_q, wb_data_d;
   logic                     pc_take_q, pc_take_d;
   logic [WORDSIZE-1:0]      pc_target_q, pc_target_d;
   logic [FLAGSIZE-1:0]      flags_q, flags_d;

   logic regwrite, movsel, memread, memwrite, condbr, uncondbr, setflags;
   logic memop, advance, taken;

   // ARMv8 condition evaluation; NV (4'hF) is treated as always.
   function automatic logic cond_pass(input logic [3:0] cc, input logic [FLAGSIZE-1:0] f);
      logic n, z, c, v, r;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cc[3:1])
         3'd0:    r = z;
         3'd1:    r = c;
         3'd2:    r = n;
         3'd3:    r = v;
         3'd4:    r = c & ~z;
         3'd5:    r = (n == v);
         3'd6:    r = ~z & (n == v);
         default: r = 1'b1;
      endcase
      if (cc[0] && cc[3:1] != 3'd7) r = ~r;
      return r;
   endfunction

   // Memory handshake: mem_req rises with address/data/we and holds them
   // stable until the one-cycle mem_ack, which is only honoured while in REQ.
   always_comb begin
      regwrite = control_in[6];
      movsel   = control_in[5];
      memread  = control_in[4];
      memwrite = control_in[3];
      condbr   = control_in[2];
      uncondbr = control_in[1];
      setflags = control_in[0];

      memop   = valid_in & (memread | memwrite);
      stall   = memop & (state_q != DONE);
      advance = valid_in & ~stall;
      taken   = uncondbr | (condbr & cond_pass(rd_in[3:0], flags_q));

      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      rdata_d       = rdata_q;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      pc_target_d   = pc_target_q;
      flags_d       = flags_q;

      case (state_q)
         IDLE: begin
            if (memop) begin
               mem_addr_d  = alures_in;
               mem_wdata_d = readreg2_in;
               mem_we_d    = memwrite;
               mem_req_d   = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               rdata_d   = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wb_valid_d    = advance;
      wb_regwrite_d = advance & regwrite;
      pc_take_d     = advance & taken;
      if (advance) begin
         wb_rd_d = rd_in;
         if (memread && !memwrite) wb_data_d = rdata_q;
         else if (movsel)          wb_data_d = movres_in;
         else                      wb_data_d = alures_in;
      end
      if (advance && taken)    pc_target_d = branchpc_in;
      if (advance && setflags) flags_d     = flags_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         rdata_q       <= '0;
         wb_valid_q    <= 1'b0;
         wb_regwrite_q <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         pc_take_q     <= 1'b0;
         pc_target_q   <= '0;
         flags_q       <= '0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         rdata_q       <= rdata_d;
         wb_valid_q    <= wb_valid_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         pc_take_q     <= pc_take_d;
         pc_target_q   <= pc_target_d;
         flags_q       <= flags_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign wb_valid    = wb_valid_q;
   assign wb_regwrite = wb_regwrite_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign pc_take     = pc_take_q;
   assign pc_target   = pc_target_q;
   assign flags       = flags_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, branches, flags and reset abort.
module tb_mem_stage;

   localparam logic [6:0] CTL_LDUR = 7'b1010000;
   localparam logic [6:0] CTL_STUR = 7'b0001000;
   localparam logic [6:0] CTL_SUBS = 7'b1000001;
   localparam logic [6:0] CTL_BCND = 7'b0000100;
   localparam logic [6:0] CTL_B    = 7'b0000010;
   localparam logic [6:0] CTL_MOV  = 7'b1100000;
   localparam logic [6:0] CTL_ALU  = 7'b1000000;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [6:0]  control_in;
   logic [63:0] branchpc_in, alures_in, movres_in, readreg2_in;
   logic [3:0]  flags_in;
   logic [4:0]  rd_in;
   logic        stall, mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic        wb_valid, wb_regwrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        pc_take;
   logic [63:0] pc_target;
   logic [3:0]  flags;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .control_in(control_in),
      .branchpc_in(branchpc_in), .alures_in(alures_in), .movres_in(movres_in),
      .readreg2_in(readreg2_in), .flags_in(flags_in), .rd_in(rd_in),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .wb_data(wb_data), .pc_take(pc_take), .pc_target(pc_target),
      .flags(flags), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      valid_in    = 1'b0;
      control_in  = 7'd0;
      mem_ack     = 1'b0;
      mem_rdata   = 64'd0;
      branchpc_in = 64'd0;
      alures_in   = 64'd0;
      movres_in   = 64'd0;
      readreg2_in = 64'd0;
      flags_in    = 4'd0;
      rd_in       = 5'd0;
   endtask

   // Drives one memory instruction until the stage stops stalling and lets it
   // advance; ack is pulsed in the ack_at-th REQ cycle. Returns at edge+1
   // after the advancing edge with inputs idled.
   task automatic run_memop(input logic [6:0] ctl, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [4:0] rd,
                            input int ack_at, input logic [63:0] rdata,
                            output int stall_cnt, output logic [63:0] cap_addr,
                            output logic [63:0] cap_wdata, output logic cap_we,
                            output logic req_ok, output logic timed_out);
      int  req_cyc;
      logic done;
      valid_in    = 1'b1;
      control_in  = ctl;
      alures_in   = addr;
      readreg2_in = wdata;
      rd_in       = rd;
      stall_cnt   = 0;
      req_cyc     = 0;
      req_ok      = 1'b1;
      timed_out   = 1'b1;
      cap_addr    = 64'd0;
      cap_wdata   = 64'd0;
      cap_we      = 1'b0;
      done        = 1'b0;
      for (int c = 0; c < 20; c++) begin
         mem_ack = 1'b0;
         if (state_dbg == ST_REQ) begin
            req_cyc++;
            if (req_cyc == 1) begin
               cap_addr  = mem_addr;
               cap_wdata = mem_wdata;
               cap_we    = mem_we;
            end
            if (!mem_req || mem_addr != cap_addr) req_ok = 1'b0;
            if (req_cyc == ack_at) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata;
            end
         end
         #1;
         if (stall) stall_cnt++;
         else done = 1'b1;
         step();
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
      drive_idle();
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      valid_in    = 1'($urandom);
      control_in  = 7'($urandom);
      branchpc_in = {$urandom, $urandom};
      alures_in   = {$urandom, $urandom};
      movres_in   = {$urandom, $urandom};
      readreg2_in = {$urandom, $urandom};
      flags_in    = 4'($urandom);
      rd_in       = 5'($urandom);
      mem_ack     = 1'($urandom);
      mem_rdata   = {$urandom, $urandom};
      step();
      step();
      drive_idle();
      #1;
      if (state_dbg !== ST_IDLE) begin $display("FAIL reset_state: got %0d want 0", state_dbg); n_errors++; end
      n_checks++;
      if ({mem_req, mem_we, wb_valid, wb_regwrite, pc_take} !== 5'd0) begin
         $display("FAIL reset_bits: got %b want 00000", {mem_req, mem_we, wb_valid, wb_regwrite, pc_take}); n_errors++;
      end
      n_checks++;
      if ({mem_addr, mem_wdata, wb_data, pc_target} !== 256'd0) begin
         $display("FAIL reset_words: addr %0h wdata %0h wb %0h pct %0h want 0", mem_addr, mem_wdata, wb_data, pc_target); n_errors++;
      end
      n_checks++;
      if ({flags, wb_rd} !== 9'd0) begin $display("FAIL reset_flags_rd: got %0h/%0h want 0", flags, wb_rd); n_errors++; end
      n_checks++;
      if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); n_errors++; end
      n_checks++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_load();
      int s; logic [63:0] a, w; logic we, ok, to;
      run_memop(CTL_LDUR, 64'h100, 64'h0, 5'd5, 3, 64'hDEAD, s, a, w, we, ok, to);
      if (to !== 1'b0) begin $display("FAIL load_timeout: stage never advanced"); n_errors++; end
      n_checks++;
      if (a !== 64'h100) begin $display("FAIL load_addr: got %0h want 100", a); n_errors++; end
      n_checks++;
      if (we !== 1'b0) begin $display("FAIL load_we: got %b want 0", we); n_errors++; end
      n_checks++;
      if (ok !== 1'b1) begin $display("FAIL load_req_hold: req not held stable"); n_errors++; end
      n_checks++;
      if (s != 4) begin $display("FAIL load_stall_cycles: got %0d want 4", s); n_errors++; end
      n_checks++;
      if ({wb_valid, wb_regwrite, wb_rd} !== {1'b1, 1'b1, 5'd5}) begin
         $display("FAIL load_wb_ctl: got %b/%b/%0d want 1/1/5", wb_valid, wb_regwrite, wb_rd); n_errors++;
      end
      n_checks++;
      if (wb_data !== 64'hDEAD) begin $display("FAIL load_wb_data: got %0h want dead", wb_data); n_errors++; end
      n_checks++;
      if ({mem_req, state_dbg} !== {1'b0, ST_IDLE}) begin
         $display("FAIL load_end_state: req %b state %0d want 0/0", mem_req, state_dbg); n_errors++;
      end
      n_checks++;
      step();
      if (wb_valid !== 1'b0 || wb_data !== 64'hDEAD) begin
         $display("FAIL load_wb_pulse: valid %b data %0h want 0/dead", wb_valid, wb_data); n_errors++;
      end
      n_checks++;
   endtask

   task automatic test_store();
      int s; logic [63:0] a, w; logic we, ok, to;
      run_memop(CTL_STUR, 64'h200, 64'h55, 5'd3, 1, 64'hBEEF, s, a, w, we, ok, to);
      if (to !== 1'b0) begin $display("FAIL store_timeout: stage never advanced"); n_errors++; end
      n_checks++;
      if ({we, w, a} !== {1'b1, 64'h55, 64'h200}) begin
         $display("FAIL store_req: we %b wdata %0h addr %0h want 1/55/200", we, w, a); n_errors++;
      end
      n_checks++;
      if (s != 2) begin $display("FAIL store_stall_cycles: got %0d want 2", s); n_errors++; end
      n_checks++;
      if ({wb_valid, wb_regwrite} !== 2'b10) begin
         $display("FAIL store_wb: valid %b regwrite %b want 1/0", wb_valid, wb_regwrite); n_errors++;
      end
      n_checks++;
      if (wb_data !== 64'h200) begin $display("FAIL store_wb_data: got %0h want 200", wb_data); n_errors++; end
      n_checks++;
      step();
   endtask

   task automatic test_branch();
      valid_in = 1'b1; control_in = CTL_SUBS; flags_in = 4'b0100; alures_in = 64'h0; rd_in = 5'd1;
      #1;
      if (stall !== 1'b0) begin $display("FAIL subs_stall: got %b want 0", stall); n_errors++; end
      n_checks++;
      step();
      control_in = CTL_BCND; rd_in = 5'd0; branchpc_in = 64'h40; flags_in = 4'b0000;
      if (flags !== 4'b0100) begin $display("FAIL subs_flags: got %b want 0100", flags); n_errors++; end
      n_checks++;
      step();
      drive_idle();
      if ({pc_take, pc_target} !== {1'b1, 64'h40}) begin
         $display("FAIL beq_taken: take %b target %0h want 1/40", pc_take, pc_target); n_errors++;
      end
      n_checks++;
      step();
      if (pc_take !== 1'b0) begin $display("FAIL beq_pulse: got %b want 0", pc_take); n_errors++; end
      n_checks++;
      valid_in = 1'b1; control_in = CTL_BCND; rd_in = 5'd1; branchpc_in = 64'h80;
      step();
      if (pc_take !== 1'b0) begin $display("FAIL bne_not_taken: got %b want 0", pc_take); n_errors++; end
      n_checks++;
      rd_in = 5'd12; branchpc_in = 64'h90;
      step();
      if (pc_take !== 1'b0) begin $display("FAIL bgt_not_taken: got %b want 0", pc_take); n_errors++; end
      n_checks++;
      rd_in = 5'd13; branchpc_in = 64'h123;
      step();
      if ({pc_take, pc_target} !== {1'b1, 64'h123}) begin
         $display("FAIL ble_taken: take %b target %0h want 1/123", pc_take, pc_target); n_errors++;
      end
      n_checks++;
      valid_in = 1'b0; control_in = CTL_B | CTL_SUBS; flags_in = 4'b1011; branchpc_in = 64'h777;
      step();
      if ({pc_take, flags, wb_valid} !== {1'b0, 4'b0100, 1'b0}) begin
         $display("FAIL invalid_ignored: take %b flags %b wbv %b want 0/0100/0", pc_take, flags, wb_valid); n_errors++;
      end
      n_checks++;
      valid_in = 1'b1; control_in = CTL_B; branchpc_in = 64'h999;
      step();
      drive_idle();
      if ({pc_take, pc_target} !== {1'b1, 64'h999}) begin
         $display("FAIL b_uncond: take %b target %0h want 1/999", pc_take, pc_target); n_errors++;
      end
      n_checks++;
      step();
   endtask

   task automatic test_reset_mid();
      valid_in = 1'b1; control_in = CTL_LDUR; alures_in = 64'h300; rd_in = 5'd7;
      step();
      if ({state_dbg, mem_req} !== {ST_REQ, 1'b1}) begin
         $display("FAIL mid_in_req: state %0d req %b want 1/1", state_dbg, mem_req); n_errors++;
      end
      n_checks++;
      rst_n = 1'b0;
      step();
      drive_idle();
      rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 64'hABCD;
      step();
      mem_ack = 1'b0;
      if ({state_dbg, mem_req, wb_valid} !== {ST_IDLE, 1'b0, 1'b0}) begin
         $display("FAIL mid_abandon: state %0d req %b wbv %b want 0/0/0", state_dbg, mem_req, wb_valid); n_errors++;
      end
      n_checks++;
      step();
      if ({state_dbg, wb_valid, flags} !== {ST_IDLE, 1'b0, 4'b0000}) begin
         $display("FAIL mid_after: state %0d wbv %b flags %b want 0/0/0000", state_dbg, wb_valid, flags); n_errors++;
      end
      n_checks++;
   endtask

   task automatic test_alu_idle_ack();
      valid_in = 1'b1; control_in = CTL_MOV; movres_in = 64'h7; alures_in = 64'h1234; rd_in = 5'd9;
      mem_ack = 1'b1; mem_rdata = 64'hBAD;
      #1;
      if (stall !== 1'b0) begin $display("FAIL mov_stall: got %b want 0", stall); n_errors++; end
      n_checks++;
      step();
      drive_idle();
      if ({wb_valid, wb_regwrite, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd9, 64'h7}) begin
         $display("FAIL mov_wb: v %b rw %b rd %0d data %0h want 1/1/9/7", wb_valid, wb_regwrite, wb_rd, wb_data); n_errors++;
      end
      n_checks++;
      if ({state_dbg, mem_req} !== {ST_IDLE, 1'b0}) begin
         $display("FAIL idle_ack_ignored: state %0d req %b want 0/0", state_dbg, mem_req); n_errors++;
      end
      n_checks++;
      step();
   endtask

   task automatic test_back_to_back();
      valid_in = 1'b1; control_in = CTL_ALU; alures_in = 64'h11; movres_in = 64'hFF; rd_in = 5'd2;
      step();
      alures_in = 64'h22; rd_in = 5'd4;
      if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 64'h11}) begin
         $display("FAIL b2b_first: v %b rd %0d data %0h want 1/2/11", wb_valid, wb_rd, wb_data); n_errors++;
      end
      n_checks++;
      step();
      drive_idle();
      if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd4, 64'h22}) begin
         $display("FAIL b2b_second: v %b rd %0d data %0h want 1/4/22", wb_valid, wb_rd, wb_data); n_errors++;
      end
      n_checks++;
      step();
   endtask

   initial begin
      drive_idle();
      rst_n = 1'b0;
      #1;
      test_reset();
      test_load();
      test_store();
      test_branch();
      test_reset_mid();
      test_alu_idle_ack();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
